fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of the IF/ID pipeline register. It owns the PC, selects the next PC from the decode-stage redirect inputs, and runs a request/ready handshake with a variable-latency instruction memory. It delivers one instruction word per cycle when memory answers in zero wait states, and inserts NOP bubbles (`RD = 0`) when memory stalls. It buffers a fetched instruction while the pipeline is stalled and discards responses made stale by a redirect.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Request/ready bus between the fetch stage and the instruction memory.
//   IMemReq   : fetch request valid (fetch -> memory)
//   IMemAddr  : fetch address, word aligned (fetch -> memory)
//   IMemReady : response valid this cycle (memory -> fetch)
//   IMemRData : instruction word, valid with IMemReady (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRData
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of a 5-stage MIPS32 pipeline. Owns the PC, picks the
// next PC from the decode-stage redirect inputs, and talks to a variable-latency
// instruction memory over a request/ready handshake. A response that arrives
// while the pipeline is stalled is parked in a one-word buffer; a response made
// stale by a redirect is dropped.
//
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   StallF       : hold fetch (redirects are ignored while high)
//   PCSrcD       : next-PC select 00 seq / 01 branch / 10 jump / 11 jr
//   PCBranchD    : branch target
//   PCJumpD      : j/jal target
//   PCJrD        : jr register target
//   imem         : instruction-memory bus (master side)
//   RD           : instruction to IF/ID, 0 (NOP) when not valid
//   PCF          : PC of the instruction on RD
//   PCPlus4F     : PCF + 4
//   InstrValidF  : RD carries a real instruction this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                StallF,
    input  logic [1:0]          PCSrcD,
    input  logic [31:0]         PCBranchD,
    input  logic [31:0]         PCJumpD,
    input  logic [31:0]         PCJrD,
    fetch_unit_if.master        imem,
    output logic [31:0]         RD,
    output logic [31:0]         PCF,
    output logic [31:0]         PCPlus4F,
    output logic                InstrValidF
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Loaded PCs are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] instr_buf_r;
    logic [31:0] instr_buf_nxt_s;
    logic        squash_r;
    logic        squash_nxt_s;
    logic [31:0] squash_addr_r;
    logic [31:0] squash_addr_nxt_s;
    logic [31:0] npc_s;
    logic        redirect_s;
    logic        valid_s;

    assign redirect_s = (PCSrcD != 2'b00);

    // Next-PC select from the decode-stage redirect inputs.
    always_comb begin
        npc_s = pc_r + 32'd4;
        case (PCSrcD)
            2'b00:   npc_s = align_pc(pc_r + 32'd4);
            2'b01:   npc_s = align_pc(PCBranchD);
            2'b10:   npc_s = align_pc(PCJumpD);
            2'b11:   npc_s = align_pc(PCJrD);
            default: npc_s = align_pc(pc_r + 32'd4);
        endcase
    end

    // While a stale request is outstanding the bus keeps the old address.
    assign imem.IMemReq  = (state_r == ST_REQ) & ~RST;
    assign imem.IMemAddr = squash_r ? squash_addr_r : pc_r;

    assign valid_s = ~RST & ((state_r == ST_HOLD) |
                             ((state_r == ST_REQ) & imem.IMemReady & ~squash_r));
    assign InstrValidF = valid_s;
    assign PCF         = RST ? RESET_PC : pc_r;
    assign PCPlus4F    = PCF + 32'd4;

    // Instruction mux: parked word in HOLD, zero-cycle bypass in REQ, else NOP.
    always_comb begin
        RD = 32'd0;
        if (RST) begin
            RD = 32'd0;
        end else if (state_r == ST_HOLD) begin
            RD = instr_buf_r;
        end else if (valid_s) begin
            RD = imem.IMemRData;
        end else begin
            RD = 32'd0;
        end
    end

    // Next-state logic for the REQ/HOLD controller and its datapath registers.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        instr_buf_nxt_s   = instr_buf_r;
        squash_nxt_s      = squash_r;
        squash_addr_nxt_s = squash_addr_r;
        case (state_r)
            ST_REQ: begin
                if (imem.IMemReady && squash_r) begin
                    // Stale response: drop it; the new target is already in pc_r.
                    squash_nxt_s = 1'b0;
                    if (!StallF && redirect_s) begin
                        pc_nxt_s = npc_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else if (imem.IMemReady && !StallF) begin
                    pc_nxt_s = npc_s;
                end else if (imem.IMemReady) begin
                    instr_buf_nxt_s = imem.IMemRData;
                    state_nxt_s     = ST_HOLD;
                end else if (!StallF && redirect_s) begin
                    // Only the first redirect records the in-flight address.
                    if (!squash_r) begin
                        squash_addr_nxt_s = pc_r;
                        squash_nxt_s      = 1'b1;
                    end else begin
                        squash_addr_nxt_s = squash_addr_r;
                    end
                    pc_nxt_s = npc_s;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!StallF) begin
                    pc_nxt_s    = npc_s;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            instr_buf_r   <= 32'd0;
            squash_r      <= 1'b0;
            squash_addr_r <= 32'd0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            instr_buf_r   <= instr_buf_nxt_s;
            squash_r      <= squash_nxt_s;
            squash_addr_r <= squash_addr_nxt_s;
        end
    end

endmodule
